dff_share_arbiter: RTL and testbench

DFF_SHARE_ARBITER -- requirements
Module: dff_share_arbiter

---
 rtl/dff_arb_pkg.sv | 14 +
 rtl/dff_share_arbiter_rr_pick.sv | 32 +++
 rtl/dff_share_arbiter.sv | 88 ++++++++
 tb/tb_dff_share_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared types and default constants for the shared-register arbiter.
package dff_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_DW          = 1;
  localparam int DEF_HOLD_CYCLES = 3;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request found
// starting one position past ptr wins, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win
);

  logic found;
  int   idx;

  // Rotating priority search; only the first hit is granted
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// One storage register shared by NREQ requesters. A round-robin grant
// captures the winner's data, then an optional lockout of HOLD_CYCLES
// cycles blocks further captures. Requests are never queued.
module dff_share_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int DW          = DEF_DW,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       din,
  output logic [NREQ-1:0]          gnt,
  output logic [DW-1:0]            q,
  output logic [DW-1:0]            qn,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     q_valid,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    ptr;
  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_win;
  logic             fire;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .win (pick_win)
  );

  // Grants only leave the block in IDLE and never while reset is held
  assign gnt  = (!rst && state == IDLE) ? pick_gnt : '0;
  assign fire = |gnt;
  assign qn   = ~q;

  // Capture on a grant edge, then count out the lockout before reopening
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      owner   <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      ptr     <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            q       <= din[int'(pick_win)*DW +: DW];
            owner   <= pick_win;
            q_valid <= 1'b1;
            ptr     <= pick_win;
            if (HOLD_CYCLES > 0) begin
              state <= HOLD;
              busy  <= 1'b1;
              cnt   <= CNT_W'(HOLD_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: directed scenarios plus a randomized run
// against a behavioural model; a second instance covers zero lockout.
module tb_dff_share_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with the default three-cycle lockout
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [0:0] q, qn;
  logic [1:0] owner;
  logic       q_valid, busy;

  // Instance with no lockout
  logic       rst0;
  logic [3:0] req0;
  logic [3:0] din0;
  logic [3:0] gnt0;
  logic [0:0] q0, qn0;
  logic [1:0] owner0;
  logic       q_valid0, busy0;

  dff_share_arbiter #(.NREQ(4), .DW(1), .HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .q(q), .qn(qn),
    .owner(owner), .q_valid(q_valid), .busy(busy)
  );

  dff_share_arbiter #(.NREQ(4), .DW(1), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .din(din0), .gnt(gnt0), .q(q0), .qn(qn0),
    .owner(owner0), .q_valid(q_valid0), .busy(busy0)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of the lockout instance
  logic m_q;
  logic m_valid;
  int   m_owner;
  int   m_ptr;
  int   m_hold;   // lockout cycles still to run

  function automatic logic [3:0] model_gnt(input logic r, input logic [3:0] rq,
                                           input int ptr, input int hold);
    if (r || hold > 0 || rq == 4'b0000) return 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      if (rq[(ptr + k) % 4]) return 4'(1 << ((ptr + k) % 4));
    end
    return 4'b0000;
  endfunction

  task automatic model_clock();
    logic [3:0] g;
    g = model_gnt(rst, req, m_ptr, m_hold);
    if (rst) begin
      m_q = 1'b0; m_valid = 1'b0; m_owner = 0; m_ptr = 3; m_hold = 0;
    end else if (g != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          m_q = din[i]; m_owner = i; m_ptr = i; m_valid = 1'b1; m_hold = 3;
        end
      end
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
  endtask

  // Advance one clock with the model in lockstep; sample 1 time unit later
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; din = 4'b1111;
    tick();
    #1;
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++;
    if (q !== 1'b0 || qn !== 1'b1) begin bad++; $display("FAIL reset_q: got q=%b qn=%b want q=0 qn=1", q, qn); end
    tick();
    total++;
    if (owner !== 2'd0 || q_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got owner=%0d valid=%b busy=%b want 0 0 0", owner, q_valid, busy);
    end
  endtask

  task automatic test_single();
    logic want_busy [4];
    want_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b0; req = 4'b0100; din = 4'b0100;
    #1;
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    tick();
    req = 4'b0000;
    total++;
    if (q !== 1'b1 || qn !== 1'b0 || owner !== 2'd2 || q_valid !== 1'b1) begin
      bad++; $display("FAIL single_cap: got q=%b qn=%b owner=%0d valid=%b want 1 0 2 1", q, qn, owner, q_valid);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy !== want_busy[i]) begin bad++; $display("FAIL single_busy%0d: got %b want %b", i, busy, want_busy[i]); end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      din = 4'($urandom_range(0, 15));
      #1;
      want = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
      total++;
      if (gnt !== want) begin bad++; $display("FAIL fair_gnt c%0d: got %b want %b", c, gnt, want); end
      if (want != 4'b0000) begin
        tick();
        total++;
        if (q !== din[(c / 4) % 4] || owner !== 2'((c / 4) % 4)) begin
          bad++; $display("FAIL fair_cap c%0d: got q=%b owner=%0d want q=%b owner=%0d", c, q, owner, din[(c / 4) % 4], (c / 4) % 4);
        end
      end else begin
        tick();
      end
    end
    req = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_no_queue();
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0001; din = 4'b0001;
    tick();
    req = 4'b0010; din = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL noq_hold_gnt%0d: got %b want 0000", i, gnt); end
      tick();
    end
    req = 4'b0000; din = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (gnt !== 4'b0000 || q !== 1'b1 || owner !== 2'd0) begin
        bad++; $display("FAIL noq_idle%0d: got gnt=%b q=%b owner=%0d want 0000 1 0", i, gnt, q, owner);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_hold();
    rst = 1'b0; req = 4'b0010; din = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midhold_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || q_valid !== 1'b0 || q !== 1'b0) begin
      bad++; $display("FAIL midhold_reset: got busy=%b valid=%b q=%b want 0 0 0", busy, q_valid, q);
    end
    req = 4'b1111;
    #1;
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL midhold_regnt: got %b want 0001", gnt); end
    tick();
    req = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    logic [3:0] want;
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 24) == 0);
      req = 4'($urandom_range(0, 15));
      din = 4'($urandom_range(0, 15));
      #1;
      want = model_gnt(rst, req, m_ptr, m_hold);
      total++;
      if (gnt !== want) begin bad++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, want); end
      tick();
      total++;
      if (q !== m_q || qn !== ~m_q || owner !== 2'(m_owner) || q_valid !== m_valid || busy !== (m_hold > 0)) begin
        bad++;
        $display("FAIL rand_state c%0d: got q=%b qn=%b owner=%0d valid=%b busy=%b want q=%b owner=%0d valid=%b busy=%b",
                 c, q, qn, owner, q_valid, busy, m_q, m_owner, m_valid, m_hold > 0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_hold();
    logic [3:0] want;
    rst0 = 1'b1; req0 = 4'b1111; din0 = 4'b1010;
    @(posedge clk); #1;
    rst0 = 1'b0; req0 = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      #1;
      want = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      total++;
      if (gnt0 !== want) begin bad++; $display("FAIL zero_gnt c%0d: got %b want %b", c, gnt0, want); end
      @(posedge clk); #1;
      total++;
      if (busy0 !== 1'b0 || q0 !== 1'b1 || qn0 !== 1'b0 || owner0 !== ((c % 2 == 0) ? 2'd1 : 2'd3) || q_valid0 !== 1'b1) begin
        bad++; $display("FAIL zero_state c%0d: got busy=%b q=%b qn=%b owner=%0d valid=%b", c, busy0, q0, qn0, owner0, q_valid0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; din = '0;
    rst0 = 1'b1; req0 = '0; din0 = '0;
    m_q = 1'b0; m_valid = 1'b0; m_owner = 0; m_ptr = 3; m_hold = 0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_no_queue();
    test_reset_mid_hold();
    test_random();
    test_zero_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
